// File: rtl/operand_fwd_unit.sv
// ---------------------------------------------------------------------------
// operand_fwd_unit
//
// Operand forwarding controller for the 4-stage 8-bit pipeline (IF/ID/EX/WB).
// It keeps the last two register writes that are still in flight:
//   E0 - youngest entry, the instruction now in WB
//   E1 - older entry, written back last cycle
// It drives the select and B-side data of the two EX-input operand muxes.
//
// Ports:
//   Clk       in  1  rising-edge clock
//   Reset     in  1  asynchronous, active-high reset
//   Stall     in  1  pipeline hold; freezes E0, E1 and FwdCount
//   Flush     in  1  kill the EX instruction; its write is not captured
//   ExValid   in  1  EX stage holds a real instruction
//   ExWen     in  1  EX instruction writes a register
//   ExRd      in  3  EX destination register
//   ExResult  in  8  EX ALU result
//   SrcA      in  3  ID-stage source register, operand A
//   SrcB      in  3  ID-stage source register, operand B
//   SelA      out 1  operand-A mux select (1 = use FwdA)
//   SelB      out 1  operand-B mux select (1 = use FwdB)
//   FwdA      out 8  forwarded data for operand A
//   FwdB      out 8  forwarded data for operand B
//   FwdCount  out 8  saturating count of cycles with SelA or SelB set
// ---------------------------------------------------------------------------
module operand_fwd_unit (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Stall,
    input  logic       Flush,
    input  logic       ExValid,
    input  logic       ExWen,
    input  logic [2:0] ExRd,
    input  logic [7:0] ExResult,
    input  logic [2:0] SrcA,
    input  logic [2:0] SrcB,
    output logic       SelA,
    output logic       SelB,
    output logic [7:0] FwdA,
    output logic [7:0] FwdB,
    output logic [7:0] FwdCount
);

    typedef struct packed {
        logic       v;
        logic [2:0] rd;
        logic [7:0] data;
    } entry_t;

    entry_t     e0_q, e0_d;
    entry_t     e1_q, e1_d;
    logic [7:0] cnt_q, cnt_d;

    logic hit_a0, hit_a1, hit_b0, hit_b1;

    // Hit detection: purely combinational on source registers and state.
    always_comb begin
        hit_a0 = e0_q.v && (e0_q.rd == SrcA);
        hit_a1 = e1_q.v && (e1_q.rd == SrcA);
        hit_b0 = e0_q.v && (e0_q.rd == SrcB);
        hit_b1 = e1_q.v && (e1_q.rd == SrcB);
    end

    // Youngest entry wins when both match.
    always_comb begin
        SelA = hit_a0 | hit_a1;
        SelB = hit_b0 | hit_b1;
        FwdA = '0;
        FwdB = '0;
        if (hit_a0) begin
            FwdA = e0_q.data;
        end else if (hit_a1) begin
            FwdA = e1_q.data;
        end
        if (hit_b0) begin
            FwdB = e0_q.data;
        end else if (hit_b1) begin
            FwdB = e1_q.data;
        end
    end

    // Next-state: rd/data are captured even for invalid or flushed
    // instructions; only the valid bit is qualified.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (!Stall) begin
            e1_d.v    = e0_q.v;
            e1_d.rd   = e0_q.rd;
            e1_d.data = e0_q.data;
            e0_d.v    = ExValid & ExWen & ~Flush;
            e0_d.rd   = ExRd;
            e0_d.data = ExResult;
            if ((SelA || SelB) && (cnt_q != 8'hFF)) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign FwdCount = cnt_q;

endmodule

// File: tb/tb_operand_fwd_unit.sv
// ---------------------------------------------------------------------------
// tb_operand_fwd_unit
//
// Directed bench for operand_fwd_unit. A small reference model of the two
// write entries and the hit counter produces expected outputs; these are
// pushed to a scoreboard queue when stimulus is applied and popped when the
// DUT outputs are sampled. Directed constant checks cover the key scenarios.
// ---------------------------------------------------------------------------
module tb_operand_fwd_unit;

    logic       Clk;
    logic       Reset;
    logic       Stall;
    logic       Flush;
    logic       ExValid;
    logic       ExWen;
    logic [2:0] ExRd;
    logic [7:0] ExResult;
    logic [2:0] SrcA;
    logic [2:0] SrcB;
    logic       SelA;
    logic       SelB;
    logic [7:0] FwdA;
    logic [7:0] FwdB;
    logic [7:0] FwdCount;

    operand_fwd_unit dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Stall    (Stall),
        .Flush    (Flush),
        .ExValid  (ExValid),
        .ExWen    (ExWen),
        .ExRd     (ExRd),
        .ExResult (ExResult),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .SelA     (SelA),
        .SelB     (SelB),
        .FwdA     (FwdA),
        .FwdB     (FwdB),
        .FwdCount (FwdCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total;
    int bad;

    // Reference model state.
    logic       mv0, mv1;
    logic [2:0] mrd0, mrd1;
    logic [7:0] md0, md1;
    logic [7:0] mcnt;

    typedef struct {
        string      tag;
        logic       sa;
        logic       sb;
        logic [7:0] fa;
        logic [7:0] fb;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    task automatic model_clear();
        mv0 = 1'b0; mrd0 = '0; md0 = '0;
        mv1 = 1'b0; mrd1 = '0; md1 = '0;
        mcnt = '0;
    endtask

    task automatic model_look(input logic [2:0] src, output logic sel, output logic [7:0] d);
        sel = 1'b0;
        d   = '0;
        if (mv0 && (mrd0 == src)) begin
            sel = 1'b1;
            d   = md0;
        end else if (mv1 && (mrd1 == src)) begin
            sel = 1'b1;
            d   = md1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, updating the model with the inputs present
    // at that edge, then settle 1 time unit past the edge.
    task automatic clk_edge();
        logic       sa, sb;
        logic [7:0] fa, fb;
        model_look(SrcA, sa, fa);
        model_look(SrcB, sb, fb);
        @(posedge Clk);
        if (Reset) begin
            model_clear();
        end else if (!Stall) begin
            if ((sa || sb) && (mcnt != 8'hFF)) mcnt = mcnt + 8'd1;
            mv1  = mv0;  mrd1 = mrd0; md1 = md0;
            mv0  = ExValid & ExWen & ~Flush;
            mrd0 = ExRd;
            md0  = ExResult;
        end
        #1;
    endtask

    // Push the model's expectation for the current inputs, then pop it and
    // compare against the DUT after combinational settling.
    task automatic expect_now(input string tag);
        exp_t e;
        exp_t g;
        e.tag = tag;
        model_look(SrcA, e.sa, e.fa);
        model_look(SrcB, e.sb, e.fb);
        e.cnt = mcnt;
        sb_q.push_back(e);
        #1;
        g = sb_q.pop_front();
        chk({g.tag, ".SelA"},     {7'd0, SelA}, {7'd0, g.sa});
        chk({g.tag, ".SelB"},     {7'd0, SelB}, {7'd0, g.sb});
        chk({g.tag, ".FwdA"},     FwdA,         g.fa);
        chk({g.tag, ".FwdB"},     FwdB,         g.fb);
        chk({g.tag, ".FwdCount"}, FwdCount,     g.cnt);
    endtask

    task automatic set_ex(input logic v, input logic [2:0] rd, input logic [7:0] d);
        ExValid  = v;
        ExWen    = v;
        ExRd     = rd;
        ExResult = d;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_clear();
        Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
        set_ex(1'b0, 3'd0, 8'h00);
        SrcA = 3'd0; SrcB = 3'd0;

        // Reset state
        clk_edge();
        clk_edge();
        Reset = 1'b0;
        expect_now("reset");
        chk("reset.FwdCount", FwdCount, 8'h00);

        // Back-to-back dependency
        set_ex(1'b1, 3'd2, 8'h5A);
        clk_edge();
        set_ex(1'b0, 3'd0, 8'h00);
        SrcA = 3'd2; SrcB = 3'd4;
        expect_now("b2b");
        chk("b2b.SelA", {7'd0, SelA}, 8'h01);
        chk("b2b.FwdA", FwdA, 8'h5A);
        chk("b2b.SelB", {7'd0, SelB}, 8'h00);

        // Two-deep: both entries match rd=1, youngest wins
        SrcA = 3'd7; SrcB = 3'd1;
        set_ex(1'b1, 3'd1, 8'h11);
        clk_edge();
        set_ex(1'b1, 3'd1, 8'h22);
        clk_edge();
        expect_now("prio_young");
        chk("prio_young.FwdB", FwdB, 8'h22);

        // Older entry forwards once the younger slot is invalid
        set_ex(1'b1, 3'd1, 8'h11);
        clk_edge();
        set_ex(1'b0, 3'd1, 8'hEE);
        clk_edge();
        expect_now("prio_old");
        chk("prio_old.FwdB", FwdB, 8'h11);
        clk_edge();
        expect_now("aged_out");
        chk("aged_out.SelB", {7'd0, SelB}, 8'h00);

        // Flush: write is not captured
        SrcB = 3'd0;
        set_ex(1'b1, 3'd5, 8'h77);
        Flush = 1'b1;
        clk_edge();
        Flush = 1'b0;
        set_ex(1'b0, 3'd0, 8'h00);
        SrcA = 3'd5;
        expect_now("flush");
        chk("flush.SelA", {7'd0, SelA}, 8'h00);

        // Stall (also with Flush asserted) freezes entries and counter
        set_ex(1'b1, 3'd6, 8'h66);
        clk_edge();
        SrcA = 3'd6;
        set_ex(1'b1, 3'd3, 8'h99);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Flush = (i == 1);
            clk_edge();
            expect_now("stall");
            chk("stall.FwdA", FwdA, 8'h66);
        end
        Flush = 1'b0;
        Stall = 1'b0;
        clk_edge();
        SrcA = 3'd3;
        expect_now("post_stall");
        chk("post_stall.FwdA", FwdA, 8'h99);

        // Asynchronous reset mid-run with a live hit on rd=3
        set_ex(1'b1, 3'd3, 8'h33);
        clk_edge();
        expect_now("pre_reset");
        #2;
        Reset = 1'b1;
        model_clear();
        #1;
        chk("areset.SelA", {7'd0, SelA}, 8'h00);
        chk("areset.FwdA", FwdA, 8'h00);
        chk("areset.FwdCount", FwdCount, 8'h00);
        clk_edge();
        Reset = 1'b0;
        set_ex(1'b1, 3'd4, 8'h44);
        clk_edge();
        set_ex(1'b0, 3'd0, 8'h00);
        SrcA = 3'd4;
        expect_now("post_reset");
        chk("post_reset.FwdA", FwdA, 8'h44);

        // Saturation: continuous hit on both operands for 300 cycles
        set_ex(1'b1, 3'd7, 8'hC3);
        SrcA = 3'd7; SrcB = 3'd7;
        for (int i = 0; i < 300; i++) begin
            clk_edge();
            if ((i % 50) == 0 || i >= 253 && i <= 256) expect_now("sat_run");
        end
        expect_now("sat_end");
        chk("sat.FwdCount", FwdCount, 8'hFF);
        chk("sat.SelA", {7'd0, SelA}, 8'h01);
        chk("sat.SelB", {7'd0, SelB}, 8'h01);
        chk("sat.FwdA", FwdA, 8'hC3);
        chk("sat.FwdB", FwdB, 8'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_fwd_unit.md
# operand_fwd_unit

Operand forwarding controller for the 4-stage 8-bit pipeline (IF, ID, EX, WB). It tracks the last two register writes still in flight and drives the select (`S`) and `B`-side data of the two 8-bit 2:1 operand muxes at the EX input. Normal register-file read data feeds the muxes' `A` side. Sits between the EX/WB pipeline registers and the ALU operand muxes.

## Interface
- No parameters. Data width is 8; the register address width is 3, giving 8 general registers, all writable.
- `Clk` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-high.
- `Stall` in 1: pipeline hold; freezes all internal state.
- `Flush` in 1: kills the instruction currently in EX; its write is not captured.
- `ExValid` in 1: EX stage holds a real instruction.
- `ExWen` in 1: the EX instruction writes a register.
- `ExRd` in 3: EX destination register.
- `ExResult` in 8: EX ALU result, stable before the clock edge.
- `SrcA` in 3: ID-stage source register for operand A.
- `SrcB` in 3: ID-stage source register for operand B.
- `SelA` out 1: operand-A mux select; 1 means use `FwdA`.
- `SelB` out 1: operand-B mux select; 1 means use `FwdB`.
- `FwdA` out 8: forwarded data for operand A.
- `FwdB` out 8: forwarded data for operand B.
- `FwdCount` out 8: saturating count of cycles in which `SelA` or `SelB` was 1.

## Operation
- Internal state is two entries, each holding {v, rd[2:0], data[7:0]}:
  - E0 is the youngest entry, the instruction now in WB.
  - E1 is the older entry, written back last cycle.
- Capture rule at a rising edge with `Stall`=0:
  - E1 <= E0.
  - E0.v <= `ExValid` & `ExWen` & ~`Flush`.
  - E0.rd <= `ExRd`.
  - E0.data <= `ExResult`.
  - rd and data are captured even when v=0.
- `Stall`=1: E0, E1 and `FwdCount` all hold.
  - `Stall` has priority over `Flush`; a flushed instruction is re-presented after the stall.
- Hit detection (combinational):
  - hitA0 = E0.v & (E0.rd == `SrcA`).
  - hitA1 = E1.v & (E1.rd == `SrcA`).
  - hitB0 and hitB1 are formed the same way from `SrcB`.
- Operand A selection:
  - `SelA` = hitA0 | hitA1.
  - `FwdA` = E0.data if hitA0, else E1.data if hitA1, else 8'h00.
  - Youngest entry wins when both entries match.
- Operand B is resolved the same way, independently of A; `SrcA`==`SrcB` may forward the same data to both operands.
- `FwdCount`: increments by 1 at each non-stalled edge where (`SelA` | `SelB`)=1. It saturates at 8'hFF and does not wrap.
- Reset, asynchronous on the `Reset` rising edge and held while high:
  - E0 and E1 clear to v=0, rd=0, data=0.
  - `FwdCount` clears to 0.
  - The outputs therefore read `SelA`=0, `SelB`=0, `FwdA`=8'h00, `FwdB`=8'h00.
- Reset mid-operation discards both entries; the first valid capture after `Reset` falls is forwardable at the following cycle.

## Timing
- Capture-to-forward latency:
  - An EX result captured at edge N is visible via E0 during cycle N..N+1.
  - It is visible via E1 during cycle N+1..N+2.
  - It is not forwarded after that; the register file holds it by then.
- Source-to-select latency: `SelA`/`SelB`/`FwdA`/`FwdB` depend combinationally on `SrcA`/`SrcB` and registered state, with no clock latency.
- `ExResult` must meet setup at `Clk`; no internal path runs from `ExResult` to any output.
- `FwdCount` is registered and reflects hits up to the previous edge.

## Test plan
- Reset check: assert `Reset` mid-run with E0.v=1 (rd=3) and `SrcA`=3 -> `SelA`=0 and `FwdA`=8'h00 immediately, without waiting for an edge; `FwdCount`=0.
- Back-to-back dependency: capture rd=2, data=8'h5A; next cycle drive `SrcA`=2, `SrcB`=4 -> `SelA`=1, `FwdA`=8'h5A, `SelB`=0.
- Two-deep forwarding with priority:
  - Capture rd=1/8'h11, then rd=1/8'h22, with `SrcB`=1 -> `FwdB`=8'h22.
  - One cycle later, with an invalid capture in between -> `FwdB`=8'h11.
  - One more cycle later -> `SelB`=0.
- Flush, then Stall:
  - Capture with `Flush`=1, rd=5, data=8'h77; next cycle `SrcA`=5 -> `SelA`=0.
  - With E0 holding rd=6, assert `Stall` for 3 cycles while presenting new EX data -> E0 is unchanged and `FwdCount` is frozen.
- Saturation: hold a hit with `SrcA`=`SrcB`=E0.rd for 300 cycles by capturing the same rd repeatedly -> `FwdCount`=8'hFF and stays there; both selects are 1 with equal data.
